servant_gpio_rx: RTL and testbench

//  Receive side of the servant neighbour GPIO link. Watches a neighbour's

---
 rtl/servant_gpio_rx.sv | 106 ++++++++++
 tb/tb_servant_gpio_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/servant_gpio_rx.sv
// Receive side of the servant neighbour GPIO link: captures words on neighbour
// strobe rising edges into a small FIFO and serves them over a Wishbone responder.
module servant_gpio_rx #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic             i_gpio_clk,
    input  logic [WIDTH-1:0] i_gpio,
    input  logic [31:0]      i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    output logic             o_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             irq_en_q, irq_en_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdt_q, rdt_d;
    logic             clk_q;

    logic        rise, access, sel_status, empty, full;
    logic        do_pop, do_push, ovf_set, status_wr;
    logic [31:0] data_val, status_val;

    logic unused_bits;
    assign unused_bits = &{1'b0, i_wb_adr[31:3], i_wb_adr[1:0], i_wb_dat[31:4], i_wb_dat[1:0]};

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == COUNT_FULL);
        rise       = i_gpio_clk & ~clk_q;
        access     = i_wb_cyc & ~ack_q;
        sel_status = i_wb_adr[2];
        do_pop     = access & ~i_wb_we & ~sel_status & ~empty;
        // A pop at the same edge frees the slot, so a full FIFO still accepts the word.
        do_push    = rise & (~full | do_pop);
        ovf_set    = rise & full & ~do_pop;
        status_wr  = access & i_wb_we & sel_status;
        data_val   = empty ? 32'd0 : 32'(mem_q[rd_ptr_q]);
        status_val = {16'd0, 8'(count_q), 4'd0, irq_en_q, overflow_q, full, empty};

        wr_ptr_d   = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;
        if (status_wr) begin
            if (i_wb_dat[2]) overflow_d = 1'b0;
            irq_en_d = i_wb_dat[3];
        end
        if (ovf_set) overflow_d = 1'b1;

        ack_d = access;
        rdt_d = rdt_q;
        if (access) rdt_d = sel_status ? status_val : data_val;
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdt_q      <= 32'd0;
            clk_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            ack_q      <= ack_d;
            rdt_q      <= rdt_d;
            clk_q      <= i_gpio_clk;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst && do_push) mem_q[wr_ptr_q] <= i_gpio;
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_irq    = irq_en_q & ~empty;
endmodule

// File: tb/tb_servant_gpio_rx.sv
// Randomized and directed bench for servant_gpio_rx against a queue-based model.
module tb_servant_gpio_rx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gpio_clk = 1'b1;
    logic [31:0] gpio = '0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] m_q[$];
    bit          m_ovf, m_irq_en, m_ack, m_clk_prev = 1'b1;
    logic [31:0] m_rdt;

    always #5 clk = ~clk;

    servant_gpio_rx #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_gpio_clk(gpio_clk), .i_gpio(gpio),
        .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we), .i_wb_cyc(cyc),
        .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack), .o_irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the current inputs, then compare.
    task automatic step();
        bit          rise, access, pop, ovf_set;
        int          n;
        logic [31:0] sel;
        rise = gpio_clk && !m_clk_prev;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_irq_en = 0; m_ack = 0; m_rdt = '0; m_clk_prev = 1'b1;
        end else begin
            access = cyc && !m_ack;
            n = m_q.size();
            if (adr[2])
                sel = (32'(n) << 8) | (32'(m_irq_en) << 3) | (32'(m_ovf) << 2)
                    | (32'(n == DEPTH) << 1) | 32'(n == 0);
            else
                sel = (n == 0) ? 32'd0 : m_q[0];
            pop = access && !we && !adr[2] && n > 0;
            if (access) m_rdt = sel;
            m_ack = access;
            if (pop) void'(m_q.pop_front());
            ovf_set = 0;
            if (rise) begin
                if (m_q.size() < DEPTH) m_q.push_back(gpio);
                else ovf_set = 1;
            end
            if (access && we && adr[2]) begin
                if (dat[2]) m_ovf = 0;
                m_irq_en = dat[3];
            end
            if (ovf_set) m_ovf = 1;
            m_clk_prev = gpio_clk;
        end
        @(posedge clk);
        #1;
        check("ack", 32'(wb_ack), 32'(m_ack));
        check("rdt", wb_rdt, m_rdt);
        check("irq", 32'(irq), 32'(m_irq_en && m_q.size() > 0));
    endtask

    task automatic wb_access(input bit status, input bit wr, input logic [31:0] wdat,
                             output logic [31:0] rd);
        adr = status ? 32'h4 : 32'h0; we = wr; dat = wdat; cyc = 1'b1;
        step();
        rd = wb_rdt;
        cyc = 1'b0; we = 1'b0;
        step();
    endtask

    task automatic pulse(input logic [31:0] val);
        gpio = val; gpio_clk = 1'b1;
        step();
        gpio_clk = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] rd;

        // Strobe held high through reset must not be captured.
        rst = 1'b1; gpio_clk = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        wb_access(1, 0, 0, rd);
        check("t1_status", rd, 32'h1);
        gpio_clk = 1'b0; step();

        pulse(32'hDEADBEEF);
        pulse(32'h12345678);
        wb_access(1, 0, 0, rd); check("t2_count", rd, 32'h200);
        wb_access(0, 0, 0, rd); check("t2_rd0", rd, 32'hDEADBEEF);
        wb_access(0, 0, 0, rd); check("t2_rd1", rd, 32'h12345678);
        wb_access(1, 0, 0, rd); check("t2_empty", rd, 32'h1);

        for (int i = 1; i <= 5; i++) pulse(32'(i));
        wb_access(1, 0, 0, rd); check("t3_full_ovf", rd, 32'h406);
        for (int i = 1; i <= 4; i++) begin
            wb_access(0, 0, 0, rd); check("t3_rd", rd, 32'(i));
        end
        wb_access(1, 1, 32'h4, rd);
        wb_access(1, 0, 0, rd); check("t3_ovf_clr", rd, 32'h1);

        for (int i = 11; i <= 14; i++) pulse(32'(i));
        gpio = 32'hAA; gpio_clk = 1'b1; adr = 32'h0; we = 1'b0; cyc = 1'b1;
        step();
        check("t4_rd_same_edge", wb_rdt, 32'd11);
        cyc = 1'b0; gpio_clk = 1'b0;
        step();
        wb_access(1, 0, 0, rd); check("t4_status", rd, 32'h402);
        for (int i = 12; i <= 14; i++) begin
            wb_access(0, 0, 0, rd); check("t4_rd", rd, 32'(i));
        end
        wb_access(0, 0, 0, rd); check("t4_last", rd, 32'hAA);

        wb_access(1, 1, 32'h8, rd);
        check("t5_irq_empty", 32'(irq), 32'd0);
        gpio = 32'h55; gpio_clk = 1'b1;
        step();
        check("t5_irq_set", 32'(irq), 32'd1);
        gpio_clk = 1'b0; step();
        adr = 32'h0; we = 1'b0; cyc = 1'b1;
        step();
        check("t5_irq_clr", 32'(irq), 32'd0);
        cyc = 1'b0; step();
        wb_access(1, 1, 32'h0, rd);

        pulse(32'h101); pulse(32'h202); pulse(32'h303);
        adr = 32'h0; we = 1'b0; cyc = 1'b1;
        step(); check("t6_ack1", 32'(wb_ack), 32'd1); check("t6_d1", wb_rdt, 32'h101);
        step(); check("t6_ack2", 32'(wb_ack), 32'd0);
        step(); check("t6_ack3", 32'(wb_ack), 32'd1); check("t6_d3", wb_rdt, 32'h202);
        step(); check("t6_ack4", 32'(wb_ack), 32'd0);
        cyc = 1'b0;
        wb_access(1, 0, 0, rd); check("t6_count", rd, 32'h100);
        wb_access(0, 0, 0, rd); check("t6_last", rd, 32'h303);
        wb_access(0, 0, 0, rd); check("t6_empty_rd", rd, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            gpio_clk = ($urandom_range(0, 2) == 0);
            gpio     = $urandom;
            cyc      = ($urandom_range(0, 1) == 1);
            we       = ($urandom_range(0, 3) == 0);
            adr      = $urandom_range(0, 1) ? 32'h4 : 32'h0;
            dat      = $urandom;
            step();
        end
        rst = 1'b0; cyc = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
